// File: rtl/awg_user_top.sv
// AWG pulse-train generator: LMFC-aligned valid/zero pattern on four DAC lanes.
// Ports: DAC_CLK, i_rst (sync, active-low), DAC_READY/LMFC, trigger/stop, amps, durations, DAC_DATA0..3.
module awg_user_top #(
  parameter int          SAMPLE_W = 16,
  parameter int          SPC      = 8,
  parameter logic [15:0] IDLE_VAL = 16'h0000
) (
  input  logic                    DAC_CLK,
  input  logic                    i_rst,
  input  logic                    DAC_READY,
  input  logic                    DAC_LMFC,
  input  logic                    i_trigger,
  input  logic                    i_stop,
  input  logic [SAMPLE_W-1:0]     i_valid_amp,
  input  logic [SAMPLE_W-1:0]     i_zero_amp,
  input  logic [31:0]             i_data_duration,
  input  logic [31:0]             i_zero_duration,
  output logic [SAMPLE_W*SPC-1:0] DAC_DATA0,
  output logic [SAMPLE_W*SPC-1:0] DAC_DATA1,
  output logic [SAMPLE_W*SPC-1:0] DAC_DATA2,
  output logic [SAMPLE_W*SPC-1:0] DAC_DATA3
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    DATA = 2'd2,
    ZERO = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] dlen_q, dlen_d;
  logic [31:0] zlen_q, zlen_d;
  logic [SAMPLE_W-1:0] vamp_q, vamp_d;
  logic [SAMPLE_W-1:0] zamp_q, zamp_d;
  logic [SAMPLE_W-1:0] out_q, out_d;
  logic trig_q;

  logic trig_edge;
  logic halt;

  assign trig_edge = i_trigger & ~trig_q;
  assign halt      = i_stop | ~DAC_READY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dlen_d  = dlen_q;
    zlen_d  = zlen_q;
    vamp_d  = vamp_q;
    zamp_d  = zamp_q;
    out_d   = IDLE_VAL[SAMPLE_W-1:0];

    unique case (state_q)
      IDLE: begin
        if (trig_edge & ~halt) begin
          state_d = ARM;
          vamp_d  = i_valid_amp;
          zamp_d  = i_zero_amp;
          // Lengths kept as length-1; zero clamps to one clock.
          dlen_d  = (i_data_duration == 32'd0) ?
                    32'd0 : i_data_duration - 32'd1;
          zlen_d  = (i_zero_duration == 32'd0) ?
                    32'd0 : i_zero_duration - 32'd1;
        end
      end
      ARM: begin
        if (halt) begin
          state_d = IDLE;
        end else if (DAC_LMFC) begin
          state_d = DATA;
          cnt_d   = dlen_q;
        end
      end
      DATA: begin
        if (halt) begin
          state_d = IDLE;
        end else if (cnt_q == 32'd0) begin
          state_d = ZERO;
          cnt_d   = zlen_q;
        end else begin
          cnt_d   = cnt_q - 32'd1;
        end
      end
      ZERO: begin
        if (halt) begin
          state_d = IDLE;
        end else if (cnt_q == 32'd0) begin
          state_d = DATA;
          cnt_d   = dlen_q;
        end else begin
          cnt_d   = cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output register tracks the state being entered on this edge.
    unique case (1'b1)
      (state_d == DATA): out_d = vamp_q;
      (state_d == ZERO): out_d = zamp_q;
      default:           out_d = IDLE_VAL[SAMPLE_W-1:0];
    endcase
  end

  always_ff @(posedge DAC_CLK) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dlen_q  <= '0;
      zlen_q  <= '0;
      vamp_q  <= '0;
      zamp_q  <= '0;
      out_q   <= IDLE_VAL[SAMPLE_W-1:0];
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dlen_q  <= dlen_d;
      zlen_q  <= zlen_d;
      vamp_q  <= vamp_d;
      zamp_q  <= zamp_d;
      out_q   <= out_d;
      trig_q  <= i_trigger;
    end
  end

  assign DAC_DATA0 = {SPC{out_q}};
  assign DAC_DATA1 = {SPC{out_q}};
  assign DAC_DATA2 = {SPC{out_q}};
  assign DAC_DATA3 = {SPC{out_q}};

endmodule

// File: tb/tb_awg_user_top.sv
// Directed bench for awg_user_top.
// Expected sample values are queued per clock and checked on every lane.
module tb_awg_user_top;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ready;
  logic         lmfc;
  logic         trig;
  logic         stop;
  logic [15:0]  vamp;
  logic [15:0]  zamp;
  logic [31:0]  ddur;
  logic [31:0]  zdur;
  logic [127:0] d0, d1, d2, d3;

  logic [15:0] exp_q[$];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  awg_user_top dut (
    .DAC_CLK        (clk),
    .i_rst          (rst_n),
    .DAC_READY      (ready),
    .DAC_LMFC       (lmfc),
    .i_trigger      (trig),
    .i_stop         (stop),
    .i_valid_amp    (vamp),
    .i_zero_amp     (zamp),
    .i_data_duration(ddur),
    .i_zero_duration(zdur),
    .DAC_DATA0      (d0),
    .DAC_DATA1      (d1),
    .DAC_DATA2      (d2),
    .DAC_DATA3      (d3)
  );

  task automatic push(input logic [15:0] v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  // Advance n clocks; after each edge pop one expectation and compare.
  task automatic run(input int n);
    logic [15:0]  e;
    logic [511:0] want;
    logic [511:0] got;
    repeat (n) begin
      @(posedge clk);
      #1;
      e    = exp_q.pop_front();
      want = {32{e}};
      got  = {d3, d2, d1, d0};
      vecs++;
      assert (got === want) else begin
        errs++;
        $error("FAIL out#%0d got %h want %h", vecs, got, want);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ready = 1'b1;
    lmfc  = 1'b0;
    trig  = 1'b0;
    stop  = 1'b0;
    vamp  = 16'd10;
    zamp  = 16'd2;
    ddur  = 32'd8;
    zdur  = 32'd3;

    // Reset, with trigger and LMFC toggling underneath.
    push(16'd0, 2); run(2);
    trig = 1'b1; lmfc = 1'b1;
    push(16'd0, 2); run(2);
    trig = 1'b0; lmfc = 1'b0;
    rst_n = 1'b1;
    push(16'd0, 1); run(1);

    // Basic run: 8 x 10, 3 x 2, period 11.
    trig = 1'b1;
    push(16'd0, 1); run(1);
    push(16'd0, 2); run(2);
    lmfc = 1'b1;
    push(16'd10, 1); run(1);
    lmfc = 1'b0;
    push(16'd10, 7); push(16'd2, 3);
    push(16'd10, 8); push(16'd2, 3);
    push(16'd10, 2);
    run(23);

    // Stop pulse; trigger held high must not restart.
    stop = 1'b1;
    push(16'd0, 1); run(1);
    stop = 1'b0;
    push(16'd0, 2); run(2);
    lmfc = 1'b1;
    push(16'd0, 1); run(1);
    lmfc = 1'b0;
    trig = 1'b0;
    push(16'd0, 1); run(1);
    trig = 1'b1;
    push(16'd0, 1); run(1);
    lmfc = 1'b1;
    push(16'd10, 1); run(1);
    lmfc = 1'b0;
    push(16'd10, 3); run(3);

    // Link drop mid-run, then trigger while link is down.
    ready = 1'b0;
    push(16'd0, 1); run(1);
    ready = 1'b1;
    push(16'd0, 1); run(1);
    trig = 1'b0; ready = 1'b0;
    push(16'd0, 1); run(1);
    trig = 1'b1;
    push(16'd0, 1); run(1);
    ready = 1'b1; lmfc = 1'b1;
    push(16'd0, 2); run(2);
    lmfc = 1'b0;

    // Trigger edge coincident with stop in IDLE is dropped.
    trig = 1'b0;
    push(16'd0, 1); run(1);
    trig = 1'b1; stop = 1'b1;
    push(16'd0, 1); run(1);
    stop = 1'b0; lmfc = 1'b1;
    push(16'd0, 2); run(2);
    lmfc = 1'b0;

    // Zero durations clamp to 1; mid-run input changes ignored.
    trig = 1'b0;
    vamp = 16'd7; zamp = 16'd3;
    ddur = 32'd0; zdur = 32'd0;
    push(16'd0, 1); run(1);
    trig = 1'b1;
    push(16'd0, 1); run(1);
    lmfc = 1'b1;
    push(16'd7, 1); run(1);
    lmfc = 1'b0;
    vamp = 16'h0099; zamp = 16'h0098;
    ddur = 32'd5; zdur = 32'd5;
    repeat (3) begin
      push(16'd3, 1); push(16'd7, 1);
    end
    run(6);

    // Retrigger picks up the new amplitudes and lengths.
    stop = 1'b1;
    push(16'd0, 1); run(1);
    stop = 1'b0; trig = 1'b0;
    push(16'd0, 1); run(1);
    trig = 1'b1;
    push(16'd0, 1); run(1);
    lmfc = 1'b1;
    push(16'h0099, 1); run(1);
    lmfc = 1'b0;
    push(16'h0099, 4); push(16'h0098, 5);
    push(16'h0099, 2);
    run(11);

    // Reset mid-DATA.
    rst_n = 1'b0;
    push(16'd0, 2); run(2);
    rst_n = 1'b1; trig = 1'b0; lmfc = 1'b1;
    push(16'd0, 2); run(2);
    lmfc = 1'b0;
    push(16'd0, 1); run(1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
